// File: rtl/token_drop_if.sv
// Drop-request handshake and result bundle between the game logic and the board controller.
interface token_drop_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic          req_valid;
  logic [CW-1:0] req_col;
  logic          req_player;
  logic          req_ready;
  logic          done;
  logic          err;
  logic [RW-1:0] res_row;

  modport master (
    output req_valid, req_col, req_player,
    input  req_ready, done, err, res_row
  );

  modport slave (
    input  req_valid, req_col, req_player,
    output req_ready, done, err, res_row
  );
endinterface

// File: rtl/token_drop_ctrl.sv
// Connect-four board state, column-drop FSM and per-cell colour decode.
// Define TOKEN_DROP_HIGHLIGHT_LAST_EN to blink the most recently placed token.
module token_drop_ctrl #(
  parameter int          ROWS      = 6,
  parameter int          COLS      = 7,
  parameter logic [23:0] EMPTY_RGB = 24'h000000,
  parameter logic [23:0] P1_RGB    = 24'hFF0000,
  parameter logic [23:0] P2_RGB    = 24'hFFFF00
`ifdef TOKEN_DROP_HIGHLIGHT_LAST_EN
  ,
  parameter logic [23:0] HL_RGB       = 24'hFFFFFF,
  parameter int          BLINK_CYCLES = 25000000
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  token_drop_if.slave              bus,
  output logic                     board_full,
  output logic [2*ROWS*COLS-1:0]   cell_state,
  output logic [24*ROWS*COLS-1:0]  cell_rgb
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int NC = ROWS * COLS;
  localparam int IW = $clog2(NC);

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_WRITE, S_DONE, S_ERR} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_player;
  logic [1:0]    r_cells [NC];
  logic [IW-1:0] w_idx;
  logic          w_cell_occ;
  logic          w_accept;
  logic          w_dec;
  logic          w_write;

  always_comb begin
    w_idx      = IW'(r_row) * IW'(COLS) + IW'(r_col);
    w_cell_occ = (r_cells[w_idx] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_state <= S_IDLE;
    else if (clear) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_dec         = 1'b0;
    w_write       = 1'b0;
    bus.req_ready = (r_state == S_IDLE);
    bus.done      = (r_state == S_DONE);
    bus.err       = (r_state == S_ERR);
    bus.res_row   = r_row;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (int'(bus.req_col) >= COLS) ? S_ERR : S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (!w_cell_occ)       w_state_nxt = S_WRITE;
        else if (r_row == '0)  w_state_nxt = S_ERR;
        else                   w_dec       = 1'b1;
      end
      S_WRITE: begin
        w_write     = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row    <= '0;
      r_col    <= '0;
      r_player <= 1'b0;
      for (int unsigned i = 0; i < NC; i++) r_cells[i] <= '0;
    end else if (clear) begin
      r_row    <= '0;
      r_col    <= '0;
      r_player <= 1'b0;
      for (int unsigned i = 0; i < NC; i++) r_cells[i] <= '0;
    end else begin
      if (w_accept) begin
        r_col    <= bus.req_col;
        r_player <= bus.req_player;
        r_row    <= RW'(ROWS - 1);
      end
      if (w_dec)   r_row <= r_row - 1'b1;
      if (w_write) r_cells[w_idx] <= {r_player, ~r_player};
    end
  end

  // Top row is row 0, so cells 0..COLS-1.
  always_comb begin
    board_full = 1'b1;
    for (int unsigned c = 0; c < COLS; c++)
      if (r_cells[c] == 2'b00) board_full = 1'b0;
  end

  always_comb begin
    cell_state = '0;
    for (int unsigned i = 0; i < NC; i++) cell_state[2*i +: 2] = r_cells[i];
  end

  function automatic logic [23:0] code_rgb(input logic [1:0] code);
    case (code)
      2'b01:   return P1_RGB;
      2'b10:   return P2_RGB;
      default: return EMPTY_RGB;
    endcase
  endfunction

`ifdef TOKEN_DROP_HIGHLIGHT_LAST_EN
  localparam int BW = $clog2(BLINK_CYCLES) + 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic [IW-1:0] r_last_idx;
  logic          r_last_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_last_idx  <= '0;
      r_last_vld  <= 1'b0;
    end else if (clear) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_last_vld  <= 1'b0;
    end else begin
      if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
      if (w_write) begin
        r_last_idx <= w_idx;
        r_last_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    cell_rgb = '0;
    for (int unsigned i = 0; i < NC; i++)
      cell_rgb[24*i +: 24] = (r_last_vld && r_blink && (IW'(i) == r_last_idx))
                             ? HL_RGB : code_rgb(r_cells[i]);
  end
`else
  always_comb begin
    cell_rgb = '0;
    for (int unsigned i = 0; i < NC; i++) cell_rgb[24*i +: 24] = code_rgb(r_cells[i]);
  end
`endif

endmodule

// File: tb/tb_token_drop_ctrl.sv
// Directed bench for token_drop_ctrl: board model plus scoreboard of expected drop outcomes.
module tb_token_drop_ctrl;
  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int NC   = ROWS * COLS;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic board_full;
  logic [2*NC-1:0]  cell_state;
  logic [24*NC-1:0] cell_rgb;

  token_drop_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  token_drop_ctrl #(
    .ROWS(ROWS),
    .COLS(COLS)
`ifdef TOKEN_DROP_HIGHLIGHT_LAST_EN
    ,
    .BLINK_CYCLES(4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus),
    .board_full (board_full),
    .cell_state (cell_state),
    .cell_rgb   (cell_rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [2:0] row;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m [NC];
  int         m_last;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [1:0] code);
    case (code)
      2'b01:   return 24'hFF0000;
      2'b10:   return 24'hFFFF00;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) m[i] = 2'b00;
    m_last = -1;
  endtask

  task automatic check_board(input string tag);
    logic        bf;
    logic [23:0] er;
    logic [23:0] gr;
    bf = 1'b1;
    for (int c = 0; c < COLS; c++) if (m[c] == 2'b00) bf = 1'b0;
    check({tag, "_board_full"}, board_full, bf);
    for (int i = 0; i < NC; i++) begin
      check($sformatf("%s_state%0d", tag, i), cell_state[2*i +: 2], m[i]);
      gr = cell_rgb[24*i +: 24];
      er = exp_rgb(m[i]);
`ifdef TOKEN_DROP_HIGHLIGHT_LAST_EN
      if (i == m_last && gr == 24'hFFFFFF) er = 24'hFFFFFF;
`endif
      check($sformatf("%s_rgb%0d", tag, i), gr, er);
    end
  endtask

  // Called at a negedge; returns at the negedge after the post-result cycle.
  task automatic drop(input int col, input bit p, input bit hold);
    exp_t e;
    exp_t g;
    int   n;
    e.is_err = 1'b1;
    e.row    = '0;
    e.lat    = 1;
    if (col < COLS) begin
      e.lat = ROWS + 1;
      for (int r = ROWS - 1; r >= 0; r--) begin
        if (m[r*COLS + col] == 2'b00) begin
          e.is_err = 1'b0;
          e.row    = 3'(r);
          e.lat    = 3 + (ROWS - 1 - r);
          break;
        end
      end
    end
    sb.push_back(e);
    check("ready_before_req", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_col    = 3'(col);
    bus.req_player = p;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    if (!hold) bus.req_valid = 1'b0;
    while (!bus.done && !bus.err && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b0;
    g = sb.pop_front();
    check($sformatf("latency_c%0d", col), n, g.lat);
    check($sformatf("done_c%0d", col), bus.done, !g.is_err);
    check($sformatf("err_c%0d", col), bus.err, g.is_err);
    if (!g.is_err) begin
      check($sformatf("res_row_c%0d", col), bus.res_row, g.row);
      m[g.row*COLS + col] = p ? 2'b10 : 2'b01;
      m_last = g.row*COLS + col;
    end
    check_board("after_drop");
    @(negedge clk);
    check("done_single_pulse", bus.done, 0);
    check("err_single_pulse", bus.err, 0);
    check("ready_after", bus.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    clear          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_col    = '0;
    bus.req_player = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_res_row", bus.res_row, 0);
    check_board("rst");
    rst = 1'b0;
    @(negedge clk);

    // First drop lands on the bottom row
    drop(3, 1'b0, 1'b0);
    check("cell38_state", cell_state[76 +: 2], 2'b01);
    check("cell38_rgb", cell_rgb[38*24 +: 24], 24'hFF0000);

    // Stacking in the same column
    drop(3, 1'b1, 1'b0);
    drop(3, 1'b0, 1'b0);
    check("cell31_state", cell_state[62 +: 2], 2'b10);
    check("cell24_state", cell_state[48 +: 2], 2'b01);

    // Fill column 0, then overflow it
    for (int i = 0; i < ROWS; i++) drop(0, 1'(i % 2), 1'b0);
    drop(0, 1'b1, 1'b0);

    // Out-of-range column, then a request held high through the whole transaction
    drop(7, 1'b0, 1'b0);
    drop(5, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("hold_no_done", bus.done, 0);
      check("hold_no_err", bus.err, 0);
    end
    check_board("after_hold");

    // Clear during SEARCH into a column holding 3 tokens
    for (int i = 0; i < 3; i++) drop(2, 1'(i % 2), 1'b0);
    bus.req_valid  = 1'b1;
    bus.req_col    = 3'd2;
    bus.req_player = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    check("clear_done", bus.done, 0);
    check("clear_err", bus.err, 0);
    check("clear_ready", bus.req_ready, 1);
    check_board("clear");
    repeat (4) begin
      @(negedge clk);
      check("post_clear_done", bus.done, 0);
      check("post_clear_err", bus.err, 0);
    end

    // Asynchronous reset asserted while the FSM is in WRITE
    drop(4, 1'b0, 1'b0);
    bus.req_valid  = 1'b1;
    bus.req_col    = 3'd4;
    bus.req_player = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_mid_ready", bus.req_ready, 1);
    check("rst_mid_done", bus.done, 0);
    check("rst_mid_err", bus.err, 0);
    check("rst_mid_res_row", bus.res_row, 0);
    check_board("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", bus.done, 0);
      check("post_rst_err", bus.err, 0);
    end

    // Fill the whole board; board_full tracks the top row throughout
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) drop(c, 1'((r + c) % 2), 1'b0);
    check("board_full_final", board_full, 1);
    drop(6, 1'b0, 1'b0);

`ifdef TOKEN_DROP_HIGHLIGHT_LAST_EN
    begin : blk_blink
      logic [23:0] s [16];
      int          i0;
      for (int j = 0; j < 16; j++) begin
        s[j] = cell_rgb[m_last*24 +: 24];
        @(negedge clk);
      end
      i0 = 0;
      for (int j = 1; j < 6; j++) if (i0 == 0 && s[j] != s[j-1]) i0 = j;
      check("blink_edge_found", (i0 != 0), 1);
      if (i0 == 0) i0 = 1;
      check("blink_has_hl", (s[i0] == 24'hFFFFFF) || (s[i0-1] == 24'hFFFFFF), 1);
      check("blink_player_colour", (s[i0] == 24'hFFFFFF) ? s[i0-1] : s[i0], exp_rgb(m[m_last]));
      for (int j = i0; j < 16; j++)
        check($sformatf("blink_phase%0d", j), s[j], ((((j - i0) / 4) % 2) == 0) ? s[i0] : s[i0-1]);
    end
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/token_drop_ctrl.md
Name: token_drop_ctrl

Overview:
- Game-board controller for the connect-four VGA display.
- Holds the ROWS x COLS cell state and accepts column-drop requests over a valid/ready handshake.
- An FSM scans the requested column from the bottom up, writes the player's token, and reports the landing row or an error.
- Produces one flat 24-bit colour per cell, which drives the per-cell rgb inputs of the display colour mux.

Parameters:
ROWS, 6, board rows; row 0 is the top row
COLS, 7, board columns; column 0 is the leftmost
EMPTY_RGB, 24'h000000, colour of an empty cell
P1_RGB, 24'hFF0000, colour of a player-0 token
P2_RGB, 24'hFFFF00, colour of a player-1 token
HL_RGB, 24'hFFFFFF, blink colour (optional feature only)
BLINK_CYCLES, 25000000, blink half-period in clocks (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous board clear / abort
req_valid  in  1  drop request valid
req_col  in  $clog2(COLS)  target column
req_player  in  1  0 = player 0, 1 = player 1
req_ready  out  1  controller can accept a request
done  out  1  one-cycle pulse: token placed
err  out  1  one-cycle pulse: column full or column index out of range
res_row  out  $clog2(ROWS)  landing row, valid while done=1
board_full  out  1  every top-row cell occupied
cell_state  out  2*ROWS*COLS  per cell: 00 empty, 01 player 0, 10 player 1; cell index = row*COLS+col, LSBs hold cell 0
cell_rgb  out  24*ROWS*COLS  per-cell colour, same indexing as cell_state

Behaviour:
- Reset (async, rst=1):
  - All cells 00.
  - FSM in IDLE.
  - req_ready=1, done=0, err=0, res_row=0.
  - Row counter and latched column/player cleared.
- States: IDLE, SEARCH, WRITE, DONE, ERR. All outputs except cell_rgb and board_full are registered or decoded from state.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch req_col and req_player.
  - If req_col>=COLS, go to ERR.
  - Otherwise set row=ROWS-1 and go to SEARCH.
  - req_valid=0 leaves the state unchanged.
- SEARCH:
  - One row is checked per cycle at (row, col).
  - If the cell is empty, go to WRITE with row held.
  - If the cell is occupied and row==0, go to ERR.
  - If the cell is occupied and row>0, decrement row and stay.
- WRITE: store {player, ~player} into cell (row, col), go to DONE.
- DONE: done=1, res_row=row, go to IDLE.
- ERR: err=1, go to IDLE. Board unchanged.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored; no queueing.
- Latency, with k tokens already in the column (request accepted at cycle T):
  - Placement: done at cycle T+3+k; the new cell is visible on cell_state in the same cycle.
  - Full column: err at T+ROWS+1.
  - Out-of-range column: err at T+1.
- done and err are never asserted together. Each is a single-cycle pulse.
- clear (any state):
  - Next edge: all cells 00, FSM to IDLE, no done/err pulse.
  - An in-flight request is dropped.
  - clear takes priority over a simultaneous request accept.
- board_full is combinational: AND over the top row (row 0) of cell_state!=00. It does not block requests; a drop into a full column still returns err.
- cell_rgb is combinational from cell_state: 00 maps to EMPTY_RGB, 01 to P1_RGB, 10 to P2_RGB. Code 11 is unreachable and maps to EMPTY_RGB.
- Row counter: $clog2(ROWS) bits, no wrap. SEARCH exits at row 0 before any decrement.

Optional Feature:
- Macro: TOKEN_DROP_HIGHLIGHT_LAST_EN.
- When defined:
  - Register last_idx (valid after first placement) and last_vld.
  - A free-running counter toggles a blink bit every BLINK_CYCLES clocks.
  - While the blink bit is 1, cell_rgb of last_idx shows HL_RGB instead of the player colour.
  - rst and clear reset last_vld, the counter and the blink bit to 0.
- When undefined: no counter or last_idx logic; colours are static as above.

Test Plan:
1. Reset, then drop col=3, player=0 -> done at T+3, res_row=5, cell 38 = 01, cell_rgb[38] = 24'hFF0000.
2. Two more drops into col 3 (players 1, 0) -> res_row=4 at T+4, then res_row=3 at T+5; cell 31 = 10, cell 24 = 01.
3. Fill col 0 with 6 drops, then drop a 7th -> err at T+7, no done, cell_state unchanged, req_ready back to 1 at T+8.
4. req_col=7 -> err at T+1, board unchanged. req_valid held high during SEARCH -> ignored, exactly one placement.
5. Assert clear during SEARCH of a drop into a column holding 3 tokens -> all cells 00 next cycle, no done/err, req_ready=1. Separately, rst asserted mid-WRITE -> immediate reset values.
6. Fill all top-row cells -> board_full=1. With TOKEN_DROP_HIGHLIGHT_LAST_EN and BLINK_CYCLES=4 -> last cell alternates P colour / 24'hFFFFFF every 4 clocks.
